// File: rtl/ultrasonic_distance_meter_pkg.sv
// Purpose : shared types and default timing for the ultrasonic distance meter.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIGGER,
        WAIT_ECHO,
        MEASURE,
        HOLDOFF
    } meas_state_t;

    localparam int CLK_HZ    = 50_000_000;
    localparam int SOUND_MPS = 343;

    // One 0.01 cm step of distance is 2e-4 m of round-trip flight.
    // At 343 m/s and 50 MHz this is 29 clk cycles (truncated).
    localparam int DEF_TICK_CYCLES        = (2 * CLK_HZ) / (SOUND_MPS * 10_000);
    localparam int DEF_WIDTH              = 13;
    localparam int DEF_TRIG_CYCLES        = CLK_HZ / 100_000;     // 10 us
    localparam int DEF_ECHO_WAIT_CYCLES   = CLK_HZ / 1_000;       // 1 ms
    localparam int DEF_ECHO_MAX_CYCLES    = (CLK_HZ * 3) / 100;   // 30 ms
    localparam int DEF_MEAS_PERIOD_CYCLES = (CLK_HZ * 6) / 100;   // 60 ms

    // Bits needed for a counter that must hold values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ultrasonic_distance_meter_sync_2ff.sv
// Purpose : two-flop synchronizer for asynchronous inputs.
// Latency : 2 clk cycles, identical for rising and falling edges.
// Backpressure: none; samples every cycle.
// Ports   : clk, reset (sync active-high), d (async in), q (synchronized out).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ultrasonic_distance_meter.sv
// Purpose : HC-SR04 driver: periodic trigger, echo width -> distance in 0.01 cm.
// Latency : result 1 cycle after synchronized echo fall (echo path adds 2 cycles).
// Backpressure: none; valid is a one-cycle strobe, distance/timeout hold until next.
// Ports   : clk, reset (sync active-high), enable, echo (async) ->
//           trig, distance[WIDTH], valid, timeout.
module ultrasonic_distance_meter
    import ultrasonic_pkg::*;
#(
    parameter int WIDTH              = DEF_WIDTH,
    parameter int TRIG_CYCLES        = DEF_TRIG_CYCLES,
    parameter int TICK_CYCLES        = DEF_TICK_CYCLES,
    parameter int ECHO_WAIT_CYCLES   = DEF_ECHO_WAIT_CYCLES,
    parameter int ECHO_MAX_CYCLES    = DEF_ECHO_MAX_CYCLES,
    parameter int MEAS_PERIOD_CYCLES = DEF_MEAS_PERIOD_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             echo,
    output logic             trig,
    output logic [WIDTH-1:0] distance,
    output logic             valid,
    output logic             timeout
);

    localparam int PW = cnt_w(MEAS_PERIOD_CYCLES);
    localparam int WW = cnt_w(ECHO_WAIT_CYCLES);
    localparam int HW = cnt_w(ECHO_MAX_CYCLES);
    localparam int SW = cnt_w(TICK_CYCLES);

    localparam logic [PW-1:0]    TRIG_LAST   = PW'(TRIG_CYCLES - 1);
    localparam logic [PW-1:0]    PERIOD_LAST = PW'(MEAS_PERIOD_CYCLES - 1);
    localparam logic [WW-1:0]    WAIT_LAST   = WW'(ECHO_WAIT_CYCLES - 1);
    localparam logic [HW-1:0]    HIGH_LAST   = HW'(ECHO_MAX_CYCLES - 1);
    localparam logic [SW-1:0]    SUB_LAST    = SW'(TICK_CYCLES - 1);
    localparam logic [WIDTH-1:0] DIST_MAX    = {WIDTH{1'b1}};

    meas_state_t      state, state_next;
    logic             echo_s;
    logic             start;      // entering TRIGGER: new period begins
    logic             done_good;  // echo fell inside the measurement window
    logic             done_to;    // no echo in time or echo too long
    logic             count_en;   // this cycle is an echo-high cycle
    logic [PW-1:0]    period_cnt;
    logic [WW-1:0]    wait_cnt;
    logic [HW-1:0]    high_cnt;
    logic [SW-1:0]    sub_cnt;
    logic [WIDTH-1:0] dist_cnt;

    sync_2ff #(.WIDTH(1)) u_echo_sync (
        .clk   (clk),
        .reset (reset),
        .d     (echo),
        .q     (echo_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        done_good  = 1'b0;
        done_to    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = TRIGGER;
                    start      = 1'b1;
                end
            end
            TRIGGER: begin
                if (period_cnt == TRIG_LAST) begin
                    state_next = WAIT_ECHO;
                end
            end
            WAIT_ECHO: begin
                // An echo arriving on the last wait cycle still wins.
                if (echo_s) begin
                    state_next = MEASURE;
                end else if (wait_cnt == WAIT_LAST) begin
                    done_to    = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    done_good  = 1'b1;
                    state_next = HOLDOFF;
                end else if (high_cnt == HIGH_LAST) begin
                    // high_cnt excludes the current cycle, so this is count ECHO_MAX.
                    done_to    = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (period_cnt == PERIOD_LAST) begin
                    if (enable) begin
                        state_next = TRIGGER;
                        start      = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign count_en = echo_s && ((state == WAIT_ECHO) || (state == MEASURE));

    always_ff @(posedge clk) begin
        if (reset) begin
            trig       <= 1'b0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            distance   <= '0;
            period_cnt <= '0;
            wait_cnt   <= '0;
            high_cnt   <= '0;
            sub_cnt    <= '0;
            dist_cnt   <= '0;
        end else begin
            trig  <= (state_next == TRIGGER);
            valid <= done_good | done_to;

            if (start) begin
                period_cnt <= '0;
            end else if (state != IDLE) begin
                period_cnt <= period_cnt + 1'b1;
            end

            wait_cnt <= (state == WAIT_ECHO) ? wait_cnt + 1'b1 : '0;

            // dist_cnt tracks floor(high_cnt / TICK_CYCLES) without a divider.
            if (start) begin
                high_cnt <= '0;
                sub_cnt  <= '0;
                dist_cnt <= '0;
            end else if (count_en) begin
                high_cnt <= high_cnt + 1'b1;
                if (sub_cnt == SUB_LAST) begin
                    sub_cnt <= '0;
                    if (dist_cnt != DIST_MAX) begin
                        dist_cnt <= dist_cnt + 1'b1;
                    end
                end else begin
                    sub_cnt <= sub_cnt + 1'b1;
                end
            end

            if (done_good) begin
                distance <= dist_cnt;
                timeout  <= 1'b0;
            end else if (done_to) begin
                distance <= DIST_MAX;
                timeout  <= 1'b1;
            end
        end
    end

endmodule
